// File: rtl/uart_tx_scheduler_pkg.sv
// Shared encodings and defaults for the UART transmit scheduler.
package uart_tx_scheduler_pkg;

   localparam int          BYTE_W          = 8;
   localparam logic [31:0] TIMEOUT_DEFAULT = 32'd1_000_000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module uart_tx_scheduler_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int GW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [GW-1:0]    i_last,
   output logic [N_REQ-1:0] o_gnt,
   output logic [GW-1:0]    o_idx,
   output logic             o_any
);

   always_comb begin
      int          w_cand;
      logic [GW-1:0] w_cand_idx;
      o_gnt      = '0;
      o_idx      = '0;
      o_any      = 1'b0;
      w_cand     = 0;
      w_cand_idx = '0;
      // Walk from farthest to nearest so the nearest requester overwrites earlier hits.
      for (int off = N_REQ; off >= 1; off--) begin
         w_cand     = (int'(i_last) + off) % N_REQ;
         w_cand_idx = w_cand[GW-1:0];
         if (i_req[w_cand_idx]) begin
            o_gnt             = '0;
            o_gnt[w_cand_idx] = 1'b1;
            o_idx             = w_cand_idx;
            o_any             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_REQ byte producers, one frame per grant,
// with a watchdog that aborts a request the transmitter never takes.
//
// state | meaning
// IDLE  | waiting for tx_ready_i and a valid requester
// SEND  | tx_req_o high, waiting for the transmitter to drop ready
// DRAIN | frame in flight, waiting for ready to return
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int          N_REQ   = 4,
   parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                      clk_i,
   input  logic                      reset_n,
   input  logic [N_REQ-1:0]          req_valid_i,
   input  logic [BYTE_W*N_REQ-1:0]   req_data_i,
   output logic [N_REQ-1:0]          req_ack_o,
   output logic                      tx_req_o,
   output logic [BYTE_W-1:0]         tx_data_o,
   input  logic                      tx_ready_i,
   output logic                      busy_o,
   output logic [$clog2(N_REQ)-1:0]  grant_o,
   output logic                      timeout_o
);

   localparam int GW = $clog2(N_REQ);

   sched_state_e        r_state,   w_state_nxt;
   logic                r_tx_req,  w_tx_req_nxt;
   logic [BYTE_W-1:0]   r_tx_data, w_tx_data_nxt;
   logic [N_REQ-1:0]    r_ack,     w_ack_nxt;
   logic [GW-1:0]       r_grant,   w_grant_nxt;
   logic                r_timeout, w_timeout_nxt;
   logic [31:0]         r_wdog,    w_wdog_nxt;

   logic [N_REQ-1:0]    w_arb_gnt;
   logic [GW-1:0]       w_arb_idx;
   logic                w_arb_any;

   uart_tx_scheduler_rr_arbiter #(
      .N_REQ (N_REQ),
      .GW    (GW)
   ) u_arb (
      .i_req  (req_valid_i),
      .i_last (r_grant),
      .o_gnt  (w_arb_gnt),
      .o_idx  (w_arb_idx),
      .o_any  (w_arb_any)
   );

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_tx_req  <= 1'b0;
         r_tx_data <= '0;
         r_ack     <= '0;
         r_grant   <= GW'(N_REQ - 1);
         r_timeout <= 1'b0;
         r_wdog    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_tx_req  <= w_tx_req_nxt;
         r_tx_data <= w_tx_data_nxt;
         r_ack     <= w_ack_nxt;
         r_grant   <= w_grant_nxt;
         r_timeout <= w_timeout_nxt;
         r_wdog    <= w_wdog_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_tx_req_nxt  = r_tx_req;
      w_tx_data_nxt = r_tx_data;
      w_ack_nxt     = '0;
      w_grant_nxt   = r_grant;
      w_timeout_nxt = r_timeout;
      w_wdog_nxt    = r_wdog;
      case (r_state)
         ST_IDLE: begin
            if (tx_ready_i && w_arb_any) begin
               w_tx_data_nxt = req_data_i[{w_arb_idx, 3'b000} +: BYTE_W];
               w_ack_nxt     = w_arb_gnt;
               w_grant_nxt   = w_arb_idx;
               w_tx_req_nxt  = 1'b1;
               w_wdog_nxt    = '0;
               w_state_nxt   = ST_SEND;
            end
         end
         ST_SEND: begin
            // A falling ready always wins over an expiring watchdog on the same edge.
            if (!tx_ready_i) begin
               w_tx_req_nxt = 1'b0;
               w_state_nxt  = ST_DRAIN;
            end else if (r_wdog >= TIMEOUT - 32'd1) begin
               w_tx_req_nxt  = 1'b0;
               w_timeout_nxt = 1'b1;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_wdog_nxt = r_wdog + 32'd1;
            end
         end
         ST_DRAIN: begin
            w_tx_req_nxt = 1'b0;
            if (tx_ready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_tx_req_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
         end
      endcase
   end

   assign req_ack_o = r_ack;
   assign tx_req_o  = r_tx_req;
   assign tx_data_o = r_tx_data;
   assign busy_o    = (r_state != ST_IDLE);
   assign grant_o   = r_grant;
   assign timeout_o = r_timeout;

endmodule
